game_state_sched: RTL
=====================

# game_state_sched

Command scheduler in front of `game_state`. Arbitrates game start/stop requests from several requesters, such as the script/UART command path and the manual button path. Checks each request against the current game state and drives the `en`/`func` pulse into `game_state`. After the pulse it checks that the state actually changed, then acknowledges the requester with a pass/fail status.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters. Index 0 is the script path, index 1 the manual path.
- `SETTLE`, default 2: cycles to wait after the pulse before checking `game_state`. Legal range is 1..15.

Ports:
- `clk`, in, 1: the single clock; all logic is rising-edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, NREQ: per-requester command request. It is level-held until ack.
- `req_func`, in, 2*NREQ: per-requester command. Slice i is `[2i+1:2i]`. Codes: 2'b01 = start, 2'b10 = end, 2'b00 and 2'b11 are reserved.
- `ack`, out, NREQ: one-cycle completion pulse, one-hot.
- `ack_err`, out, 1: status, valid only while `ack` is nonzero. 1 means the command was rejected or failed.
- `busy`, out, 1: high in every state except IDLE.
- `gs_en`, out, 1: drives `game_state.en`.
- `gs_func`, out, 2: drives `game_state.func`.
- `game_state`, in, 8: feedback from `game_state`. Encodings: GAME_START = 8'h01, GAME_STOP = 8'h00.

## Operation
The FSM has four states: IDLE, ISSUE, SETTLE, RESP.

- **Reset values:** state = IDLE, `ack` = 0, `ack_err` = 0, `busy` = 0, `gs_en` = 0, `gs_func` = 2'b00, settle counter = 0, round-robin pointer `last` = NREQ-1.
- **Arbitration (IDLE only):**
  - `req` is sampled only in IDLE.
  - Round-robin: priority starts at index (`last`+1) mod NREQ and wraps.
  - The winner's index and its `req_func` are latched, and `last` is set to the winner.
  - Requests that lose stay pending and are re-arbitrated the next time the FSM is in IDLE.
- **Legality check (in IDLE, on the latched command):**
  - start is legal iff `game_state` != 8'h01.
  - end is legal iff `game_state` == 8'h01.
  - Reserved codes are always illegal.
  - Illegal: go IDLE→RESP with err=1. No `gs_en` pulse is issued.
  - Legal: go IDLE→ISSUE.
- **ISSUE:**
  - `gs_en` = 1 and `gs_func` = the latched code, for exactly one cycle.
  - Then go to SETTLE with the counter cleared.
- **SETTLE:**
  - Count SETTLE cycles.
  - On the last count, compare `game_state` with the expected value: 8'h01 for start, 8'h00 for end.
  - A mismatch sets err=1; a match sets err=0. Then go to RESP.
- **RESP:**
  - `ack[idx]` = 1 and `ack_err` = err, for one cycle. Then go to IDLE.
- **Requester rule:** a requester holds `req` and `req_func` stable until it sees ack, and drives `req` low in the cycle after ack. Changing `req_func` while pending is not supported.
- **Output defaults:** `gs_en`, `gs_func` and `ack` are 0 outside their stated states. All outputs are registered or Moore-decoded from state; none is combinational from inputs.

## Timing
E0 is the clock edge at which IDLE samples the winning request.

- **Legal command:**
  - `gs_en` is high during E0..E1.
  - The SETTLE check uses `game_state` sampled at edge E(SETTLE+1).
  - `ack` is high during E(SETTLE+1)..E(SETTLE+2).
  - Request-to-ack latency is therefore SETTLE+1 cycles.
- **Illegal command:** `ack` is high during E0..E1 (1-cycle latency), and `gs_en` stays 0.
- **Throughput:** back-to-back grants are separated by at least one IDLE cycle. Legal commands take SETTLE+3 cycles each; illegal ones take 2 cycles.
- **Simultaneous requests:** exactly one grant per IDLE visit. With NREQ=2 and both requesting continuously, grants alternate.
- **Reset mid-operation:**
  - On the edge where `rst` is sampled, the state returns to IDLE and all outputs return to their reset values.
  - Any in-flight command is dropped and no ack is produced for it.
  - `gs_en` is never left high.
- **Settle counter:** width is 4 bits. A SETTLE of 1 means the check happens on the first SETTLE cycle.

## Test plan
All scenarios use NREQ=2 and SETTLE=2, with a behavioural `game_state` model that updates one cycle after `en`.

1. **Legal start:** reset, model at 8'h00, assert req[0] with 01. Expect a `gs_en` pulse with `gs_func`=01 for one cycle after E0, and `ack[0]`=1 with `ack_err`=0 during E3..E4.
2. **Simultaneous requests:** model at 8'h01, both request 10 in the same cycle.
   - req[0] wins first: legal, `ack_err`=0.
   - req[1] is then granted: end-while-stopped, so `ack[1]`=1 with `ack_err`=1 one cycle after its sample, and no second `gs_en` pulse.
3. **Round-robin fairness:** both requesters re-request immediately after each ack, alternating 01 and 10, for 8 commands. Expect grant order 0,1,0,1,… and `ack_err`=0 throughout.
4. **Reserved code:** req[1] with 11. Expect `ack[1]`=1 and `ack_err`=1 during E0..E1, `gs_en` never asserted, `busy` high for exactly one cycle.
5. **Stuck model:** model ignores `en` and holds 8'h00; req[0] with 01. Expect a `gs_en` pulse, then `ack[0]`=1 with `ack_err`=1 at E3.
6. **Reset mid-operation:** assert `rst` during SETTLE.
   - Next cycle: all outputs 0, no ack for the dropped command.
   - After release, with both requesting, req[0] is granted first (`last` reset to 1).

Source files
------------

// File: rtl/game_state_sched.sv
// game_state_sched: round-robin start/stop command scheduler
// in front of game_state, with post-pulse state verification.
module game_state_sched #(
  parameter int NREQ   = 2,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_func,
  output logic [NREQ-1:0]   ack,
  output logic              ack_err,
  output logic              busy,
  output logic              gs_en,
  output logic [1:0]        gs_func,
  input  logic [7:0]        game_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0] LASTCNT = 4'(SETTLE - 1);
  localparam logic [IW-1:0] LASTIDX = IW'(NREQ - 1);

  localparam logic [1:0] F_START  = 2'b01;
  localparam logic [1:0] F_END    = 2'b10;
  localparam logic [7:0] GS_START = 8'h01;
  localparam logic [7:0] GS_STOP  = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] last;
  logic [IW-1:0] idx;
  logic [1:0]    func;
  logic [3:0]    cnt;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [1:0]      win_func;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] idx_oh;
  logic            win_legal;
  logic            settle_ok;

  // Round-robin pick, scanning from just after the last winner
  always_comb begin
    win_vld = 1'b0;
    win_idx = last;
    cand    = last;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last) + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Winner command slice and one-hot decodes
  always_comb begin
    win_func = 2'b00;
    win_oh   = '0;
    idx_oh   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_func  = req_func[2*i +: 2];
        win_oh[i] = 1'b1;
      end
      if (idx == IW'(i)) begin
        idx_oh[i] = 1'b1;
      end
    end
  end

  // Command legality against the current game state
  always_comb begin
    win_legal = 1'b0;
    unique case (1'b1)
      (win_func == F_START):
        win_legal = (game_state != GS_START);
      (win_func == F_END):
        win_legal = (game_state == GS_START);
      default:
        win_legal = 1'b0;
    endcase
  end

  // Post-pulse check: did game_state reach the target?
  always_comb begin
    settle_ok = (func == F_START)
              ? (game_state == GS_START)
              : (game_state == GS_STOP);
  end

  assign busy = (state != S_IDLE);

  // Sequencer: arbitrate, pulse, settle, acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      last    <= LASTIDX;
      idx     <= '0;
      func    <= 2'b00;
      cnt     <= 4'd0;
      ack     <= '0;
      ack_err <= 1'b0;
      gs_en   <= 1'b0;
      gs_func <= 2'b00;
    end else begin
      ack     <= '0;
      ack_err <= 1'b0;
      gs_en   <= 1'b0;
      gs_func <= 2'b00;
      unique case (state)
        S_IDLE: begin
          if (win_vld) begin
            idx  <= win_idx;
            func <= win_func;
            last <= win_idx;
            if (win_legal) begin
              state   <= S_ISSUE;
              gs_en   <= 1'b1;
              gs_func <= win_func;
            end else begin
              state   <= S_RESP;
              ack     <= win_oh;
              ack_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state <= S_SETTLE;
          cnt   <= 4'd0;
        end
        S_SETTLE: begin
          if (cnt == LASTCNT) begin
            state   <= S_RESP;
            ack     <= idx_oh;
            ack_err <= !settle_ok;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
